// File: rtl/fwrisc_mem_arb_pkg.sv
// Shared types and constants for the fwrisc two-port-to-one memory arbiter.
package fwrisc_mem_arb_pkg;

  localparam int FWRISC_MEM_ARB_STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } fwrisc_mem_arb_state_e;

endpackage

// File: rtl/fwrisc_mem_arb.sv
// Shares one memory port between fetch and data buses; data has priority,
// and a bounded data-grant streak guarantees fetch progress.
module fwrisc_mem_arb
  import fwrisc_mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic [31:0] idata,
  output logic        iready,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  input  logic        dvalid,
  output logic [31:0] drdata,
  output logic        dready,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  output logic        mwrite,
  output logic        mvalid,
  input  logic [31:0] mrdata,
  input  logic        mready
);

  localparam logic [FWRISC_MEM_ARB_STREAK_W-1:0] MAX_S =
    FWRISC_MEM_ARB_STREAK_W'(MAX_D_STREAK);

  fwrisc_mem_arb_state_e state, state_nxt;
  logic [FWRISC_MEM_ARB_STREAK_W-1:0] streak;
  logic grant_i, grant_d;

  assign idata  = mrdata;
  assign drdata = mrdata;

  // Grant decision and completion pulses; readies follow mready combinationally
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (dvalid && (!ivalid || (streak < MAX_S))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (ivalid) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state;
        end
      end
      default: state_nxt = IDLE;
    endcase
    iready = (state == BUSY_I) && mready;
    dready = (state == BUSY_D) && mready;
  end

  // State, streak counter and the memory-side request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
      maddr  <= 32'd0;
      mwdata <= 32'd0;
      mwstb  <= 4'd0;
      mwrite <= 1'b0;
      mvalid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d) begin
        maddr  <= daddr;
        mwdata <= dwdata;
        mwstb  <= dwstb;
        mwrite <= dwrite;
        mvalid <= 1'b1;
        // Only data grants that bypass a waiting fetch count toward the streak
        if (ivalid) begin
          streak <= (streak >= MAX_S) ? MAX_S : streak + 4'd1;
        end else begin
          streak <= '0;
        end
      end else if (grant_i) begin
        maddr  <= iaddr;
        mwdata <= 32'd0;
        mwstb  <= 4'd0;
        mwrite <= 1'b0;
        mvalid <= 1'b1;
        streak <= '0;
      end else if ((state != IDLE) && mready) begin
        mvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Directed bench for fwrisc_mem_arb: per-cycle vector table plus
// hand-written streak-fairness and mid-transaction reset sequences.
module tb_fwrisc_mem_arb;
  import fwrisc_mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic        ivalid, dvalid, dwrite, mready;
  logic [3:0]  dwstb;
  logic [31:0] idata, drdata, maddr, mwdata;
  logic [3:0]  mwstb;
  logic        iready, dready, mwrite, mvalid;

  int n_tests = 0;
  int n_fail  = 0;

  fwrisc_mem_arb #(.MAX_D_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ivalid(ivalid), .idata(idata), .iready(iready),
    .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .dvalid(dvalid), .drdata(drdata), .dready(dready),
    .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
    .mvalid(mvalid), .mrdata(mrdata), .mready(mready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  ds;
    logic        dw;
    logic        mr;
    logic [31:0] mrd;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_mw;
    logic [3:0]  e_ms;
    logic [31:0] e_md;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] ds, input logic dw,
                       input logic mr, input logic [31:0] mrd);
    ivalid = iv; iaddr = ia; dvalid = dv; daddr = da; dwdata = dwd;
    dwstb = ds; dwrite = dw; mready = mr; mrdata = mrd;
  endtask

  initial begin
    string grants;
    int    ng;
    string exp_g;

    // fetch 0x100 with one wait
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF,
                 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    // data write, then a stray mready while idle
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 32'h2000, 32'h12345678, 4'h3, 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 32'h2000, 32'h12345678, 4'h3, 1'b1, 1'b1, 32'h0,
                 1'b1, 32'h2000, 1'b1, 4'h3, 32'h12345678, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0,
                 1'b0, 32'h2000, 1'b1, 4'h3, 32'h12345678, 1'b0, 1'b0};
    // data read
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 32'h44, 32'hAAAA5555, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h2000, 1'b1, 4'h3, 32'h12345678, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0, 1'b1, 32'h44, 32'hAAAA5555, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D,
                 1'b1, 32'h44, 1'b0, 4'h0, 32'hAAAA5555, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h44, 1'b0, 4'h0, 32'hAAAA5555, 1'b0, 1'b0};
    // data request arrives during a fetch with three wait cycles
    vecs[10] = '{1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h44, 1'b0, 4'h0, 32'hAAAA5555, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h500, 1'b1, 32'h600, 32'h11112222, 4'hF, 1'b1, 1'b0, 32'h0,
                 1'b1, 32'h500, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[12] = vecs[11];
    vecs[13] = vecs[11];
    vecs[14] = '{1'b1, 32'h500, 1'b1, 32'h600, 32'h11112222, 4'hF, 1'b1, 1'b1, 32'h0BADF00D,
                 1'b1, 32'h500, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 32'h0, 1'b1, 32'h600, 32'h11112222, 4'hF, 1'b1, 1'b0, 32'h0,
                 1'b0, 32'h500, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 32'h0, 1'b1, 32'h600, 32'h11112222, 4'hF, 1'b1, 1'b1, 32'h0,
                 1'b1, 32'h600, 1'b1, 4'hF, 32'h11112222, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h600, 1'b1, 4'hF, 32'h11112222, 1'b0, 1'b0};

    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_mvalid", {31'd0, mvalid}, 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_ready", {30'd0, iready, dready}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dwd,
            vecs[i].ds, vecs[i].dw, vecs[i].mr, vecs[i].mrd);
      #1;
      chk($sformatf("v%0d_mvalid", i), {31'd0, mvalid}, {31'd0, vecs[i].e_mv});
      chk($sformatf("v%0d_maddr", i), maddr, vecs[i].e_ma);
      chk($sformatf("v%0d_mwrite", i), {31'd0, mwrite}, {31'd0, vecs[i].e_mw});
      chk($sformatf("v%0d_mwstb", i), {28'd0, mwstb}, {28'd0, vecs[i].e_ms});
      chk($sformatf("v%0d_mwdata", i), mwdata, vecs[i].e_md);
      chk($sformatf("v%0d_iready", i), {31'd0, iready}, {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_dready", i), {31'd0, dready}, {31'd0, vecs[i].e_dr});
      if (vecs[i].e_ir) chk($sformatf("v%0d_idata", i), idata, vecs[i].mrd);
      if (vecs[i].e_dr) chk($sformatf("v%0d_drdata", i), drdata, vecs[i].mrd);
    end

    // both requesters held, memory always ready: expect DDDDI repeating
    grants = "";
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      drive(1'b1, 32'h300, 1'b1, 32'h400, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
      #1;
      if (iready || dready) begin
        exp_g = (ng % 5 == 4) ? "I" : "D";
        chk($sformatf("streak_g%0d", ng), {31'd0, dready}, (exp_g == "D") ? 32'd1 : 32'd0);
        chk($sformatf("streak_a%0d", ng), maddr, (exp_g == "D") ? 32'h400 : 32'h300);
        ng++;
      end
    end
    chk("streak_count", ng, 32'd10);

    // reset in the middle of a data transaction after two streak-counted grants
    @(negedge clock);
    drive(1'b1, 32'h800, 1'b1, 32'h900, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, 32'h0);
    @(negedge clock);
    mready = 1'b1;
    #1;
    chk("pre_rst_dready", {31'd0, dready}, 32'd1);
    @(negedge clock);
    mready = 1'b0;
    @(negedge clock);
    #1;
    chk("pre_rst_mvalid", {31'd0, mvalid}, 32'd1);
    chk("pre_rst_streak", {28'd0, dut.streak}, 32'd2);
    #2 mready = 1'b1;
    #1 reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0);
    #1;
    chk("arst_mvalid", {31'd0, mvalid}, 32'd0);
    chk("arst_ready", {30'd0, iready, dready}, 32'd0);
    chk("arst_maddr", maddr, 32'd0);
    chk("arst_mwrite", {31'd0, mwrite}, 32'd0);
    chk("arst_state", {30'd0, dut.state}, {30'd0, IDLE});
    chk("arst_streak", {28'd0, dut.streak}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      chk($sformatf("post_rst_ready%0d", c), {30'd0, iready, dready}, 32'd0);
      chk($sformatf("post_rst_mvalid%0d", c), {31'd0, mvalid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwrisc_mem_arb.md
# fwrisc_mem_arb

Two-port-to-one memory arbiter for the fwrisc core. It shares a single-ported memory between the instruction-fetch bus (`iaddr`/`ivalid`/`iready`/`idata`) and the data bus (`dvalid`/`daddr`/`dwdata`/`dwstb`/`dwrite`/`drdata`/`dready`). It sits between the `fwrisc` top level and a unified SRAM or system bus. Data accesses have priority, and a bounded-streak counter guarantees fetch progress.

## Interface
- `MAX_D_STREAK`, default 4: maximum consecutive data grants while a fetch is pending; range 1–15.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `iaddr` in 32: fetch address.
- `ivalid` in 1: fetch request; held until `iready`.
- `idata` out 32: fetch read data.
- `iready` out 1: fetch complete.
- `daddr` in 32: data address.
- `dwdata` in 32: write data.
- `dwstb` in 4: byte strobes.
- `dwrite` in 1: 1 = write.
- `dvalid` in 1: data request; held until `dready`.
- `drdata` out 32: data read data.
- `dready` out 1: data complete.
- `maddr` out 32: memory address (registered).
- `mwdata` out 32: memory write data (registered).
- `mwstb` out 4: memory strobes (registered).
- `mwrite` out 1: memory write (registered).
- `mvalid` out 1: memory request (registered).
- `mrdata` in 32: memory read data.
- `mready` in 1: memory completion, one-cycle pulse qualified by `mvalid`.

## Operation
- State machine states: IDLE, BUSY_I, BUSY_D.
- IDLE, no request: stay in IDLE.
- IDLE, grant decision when `dvalid` is set:
  - Choose D if `!ivalid` or `streak < MAX_D_STREAK`.
  - Otherwise choose I.
- IDLE, `ivalid` only: choose I.
- On grant: latch the requester's address, wdata, strobes and write into the `m*` registers; set `mvalid`=1; enter BUSY_I or BUSY_D.
  - For an I grant: `mwrite`=0, `mwdata`=0, `mwstb`=0.
- BUSY_x: `m*` registers are held stable.
- BUSY_x on `mready`: clear `mvalid`, return to IDLE, and pulse the granted side's ready for that cycle.
- Completion path:
  - `iready` = (state==BUSY_I) & `mready`.
  - `dready` = (state==BUSY_D) & `mready`.
  - `idata` = `drdata` = `mrdata`, combinational.
  - Read data is valid only while the matching ready is high.
- `streak` counter, width 4:
  - Increments on a D grant while `ivalid`=1, saturating at `MAX_D_STREAK`.
  - Clears on any I grant.
  - Clears on a D grant with `ivalid`=0.
- A requester deasserting valid during BUSY is a protocol violation. The transaction still completes and the ready pulse is still issued.
- Reset (any time, including mid-transaction) forces:
  - state=IDLE, `streak`=0;
  - `mvalid`=0, `maddr`=0, `mwdata`=0, `mwstb`=0, `mwrite`=0;
  - `iready`=0, `dready`=0.
  - No in-flight response is delivered after reset.

## Timing
- Grant latency: request sampled in IDLE at edge N gives `mvalid`=1 in cycle N+1.
- Minimum transaction is 2 cycles: request seen → `mvalid` → `mready` in the same cycle.
- Responses are combinational from `mready`; no extra cycle is added on the return path.
- One IDLE cycle always separates transactions. Throughput is at most one access per 2 cycles plus memory wait states.
- Simultaneous `ivalid` and `dvalid` in IDLE are resolved by the streak rule in the same cycle.
- A request arriving while BUSY waits and is evaluated in the next IDLE cycle.
- `mready` outside BUSY is ignored.

## Structure
- Package `fwrisc_mem_arb_pkg` holds:
  - state enum `fwrisc_mem_arb_state_e` {IDLE, BUSY_I, BUSY_D};
  - constant `FWRISC_MEM_ARB_STREAK_W` = 4.
- No sub-module. A single always_ff handles state, streak and the `m*` registers; an always_comb handles grant and ready.

## Test plan
- Fetch only, `iaddr`=0x100, `mready` one cycle after `mvalid`, `mrdata`=0xDEADBEEF → `maddr`=0x100, `mwrite`=0; `iready` pulses once with `idata`=0xDEADBEEF; next cycle state is IDLE.
- Data write, `daddr`=0x2000, `dwdata`=0x12345678, `dwstb`=0x3 → `mwrite`=1, `mwstb`=0x3, `mwdata`=0x12345678; `dready` pulses once and `iready` stays 0.
- `ivalid` and `dvalid` held together continuously, `MAX_D_STREAK`=4, `mready` always 1 → grant sequence D,D,D,D,I,D,D,D,D,I,…
- Data request arriving during BUSY_I with a 3-cycle memory wait → `maddr` stays at the fetch address until `mready`; the data grant is issued the cycle after IDLE.
- `reset` asserted during BUSY_D → `mvalid`, `dready` and `iready` go to 0 immediately (async); state=IDLE, `streak`=0; the late `mready` is ignored.
